// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CPU types and constants for the common data bus.
//   NUM_FU          number of functional units that write to the CDB
//   ROB_INDEX_BITS  width of a ROB tag (ROB index)
//   DATA_BITS       width of a result value
//   cdb_t           one CDB payload {tag, data}; the ROB and reservation stations use it too
//   next_index()    round-robin successor of an index, wrapping at n (n need not be 2^k)
package cdb_arbiter_pkg;

    localparam int NUM_FU         = 4;
    localparam int ROB_INDEX_BITS = 4;
    localparam int DATA_BITS      = 32;

    typedef struct packed {
        logic [ROB_INDEX_BITS-1:0] tag;
        logic [DATA_BITS-1:0]      data;
    } cdb_t;

    function automatic int next_index(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: handshake bundle between the functional units, the arbiter and the CDB consumer.
//   req_valid/req_tag/req_data  per-unit result offers (units -> arbiter)
//   req_ready                   per-unit accept, one-hot or zero (arbiter -> units)
//   cdb_valid/tag/data/src      registered CDB slot (arbiter -> ROB/RS)
//   cdb_ready                   consumer accepts the slot (ROB/RS -> arbiter)
// Modports: master = arbiter side, slave = units/consumer side.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int num_req        = NUM_FU,
    parameter int req_index_bits = 2,
    parameter int tag_bits       = ROB_INDEX_BITS
);

    logic [num_req-1:0]                  req_valid;
    logic [num_req-1:0][tag_bits-1:0]    req_tag;
    logic [num_req-1:0][DATA_BITS-1:0]   req_data;
    logic [num_req-1:0]                  req_ready;

    logic                                cdb_valid;
    logic [tag_bits-1:0]                 cdb_tag;
    logic [DATA_BITS-1:0]                cdb_data;
    logic [req_index_bits-1:0]           cdb_src;
    logic                                cdb_ready;

    modport master (
        input  req_valid, req_tag, req_data, cdb_ready,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        output req_valid, req_tag, req_data, cdb_ready,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: purely combinational round-robin selector.
//   req_valid  in   per-requester request bits
//   ptr        in   highest-priority index for this cycle
//   grant      out  one-hot winner, zero when nobody requests
//   any        out  at least one request present
//   winner     out  encoded index of the granted requester
module rr_picker #(
    parameter int num_req        = 4,
    parameter int req_index_bits = 2
) (
    input  logic [num_req-1:0]        req_valid,
    input  logic [req_index_bits-1:0] ptr,
    output logic [num_req-1:0]        grant,
    output logic                      any,
    output logic [req_index_bits-1:0] winner
);

    int idx;

    always_comb begin
        // NOTE: every output gets a default before the scan so no path leaves a latch.
        grant  = '0;
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        // Scan ptr, ptr+1, ... modulo num_req; the first requester found wins.
        for (int k = 0; k < num_req; k++) begin
            idx = int'(ptr) + k;
            if (idx >= num_req) idx = idx - num_req;
            if (!any && req_valid[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                winner     = req_index_bits'(idx);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter and single registered slot for the common data bus.
//   clk          clock
//   rst          synchronous active-high reset
//   flush        drops the CDB slot and accepts no request this cycle
//   bus          cdb_arbiter_if.master: unit offers/accepts and the CDB slot
//   grant_count  accepted requests since reset, wraps at 2^32
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int num_req        = NUM_FU,
    parameter int req_index_bits = 2,
    parameter int tag_bits       = ROB_INDEX_BITS   // must equal ROB_INDEX_BITS so it fits cdb_t
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    cdb_arbiter_if.master        bus,
    output logic [31:0]          grant_count
);

    logic [req_index_bits-1:0] ptr;
    logic                      slot_valid;
    cdb_t                      slot;
    logic [req_index_bits-1:0] slot_src;

    logic [num_req-1:0]        grant;
    logic                      any_req;
    logic [req_index_bits-1:0] winner;
    logic                      can_load;
    logic                      transfer;

    rr_picker #(
        .num_req        (num_req),
        .req_index_bits (req_index_bits)
    ) u_picker (
        .req_valid (bus.req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .any       (any_req),
        .winner    (winner)
    );

    // The slot can take a new result when it is empty or being drained this cycle.
    // NOTE: rst gates this combinationally; with a synchronous reset the state is
    // unknown until the first edge, yet req_ready must read 0 throughout reset.
    assign can_load      = (~slot_valid | bus.cdb_ready) & ~flush & ~rst;
    assign transfer      = any_req & can_load;
    assign bus.req_ready = grant & {num_req{can_load}};

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            ptr         <= '0;
            slot_valid  <= 1'b0;
            slot        <= '0;
            slot_src    <= '0;
            grant_count <= '0;
        end else if (flush) begin
            slot_valid  <= 1'b0;
        end else if (transfer) begin
            // Drain and refill on the same edge: no bubble at full throughput.
            slot_valid  <= 1'b1;
            slot        <= '{tag: bus.req_tag[winner], data: bus.req_data[winner]};
            slot_src    <= winner;
            ptr         <= req_index_bits'(next_index(int'(winner), num_req));
            grant_count <= grant_count + 32'd1;
        end else if (bus.cdb_ready) begin
            slot_valid  <= 1'b0;   // payload held, only valid drops
        end
    end

    assign bus.cdb_valid = slot_valid;
    assign bus.cdb_tag   = slot.tag;
    assign bus.cdb_data  = slot.data;
    assign bus.cdb_src   = slot_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scoreboard bench for cdb_arbiter.
// Stimulus pushes the hand-computed CDB results into a queue; a monitor pops and
// compares each time a new result appears on the CDB slot.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int IB = 2;
    localparam int TW = 4;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [31:0]   data;
    } item_t;

    typedef struct packed {
        logic [IB-1:0] src;
        logic [TW-1:0] tag;
        logic [31:0]   data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] grant_count;

    cdb_arbiter_if #(.num_req(N), .req_index_bits(IB), .tag_bits(TW)) bus ();

    cdb_arbiter #(.num_req(N), .req_index_bits(IB), .tag_bits(TW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .grant_count (grant_count)
    );

    always #5 clk = ~clk;

    item_t uq[N][$];      // pending results per unit
    exp_t  sb[$];         // expected CDB results, in order
    int    vectors     = 0;
    int    miscompares = 0;

    logic [N-1:0] xfer_seen;
    always @(posedge clk) xfer_seen <= bus.req_valid & bus.req_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input int i, input logic [TW-1:0] tag, input logic [31:0] data);
        item_t it;
        it.tag  = tag;
        it.data = data;
        uq[i].push_back(it);
    endtask

    task automatic expect_cdb(input int src, input logic [TW-1:0] tag, input logic [31:0] data);
        exp_t e;
        e.src  = IB'(src);
        e.tag  = tag;
        e.data = data;
        sb.push_back(e);
    endtask

    // Requester model: present the next queued result, or drop valid when empty.
    task automatic load_unit(input int i);
        item_t it;
        if (uq[i].size() > 0) begin
            it = uq[i].pop_front();
            bus.req_valid[i] = 1'b1;
            bus.req_tag[i]   = it.tag;
            bus.req_data[i]  = it.data;
        end else begin
            bus.req_valid[i] = 1'b0;
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (xfer_seen[i]) load_unit(i);
    endtask

    // Monitor: a result is new when the slot is valid and last cycle it was empty or drained.
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.cdb_valid === 1'b1 && (prev_valid !== 1'b1 || prev_ready === 1'b1)) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected: got src %0d tag %0h data %0h, required nothing",
                         bus.cdb_src, bus.cdb_tag, bus.cdb_data);
            end else begin
                e = sb.pop_front();
                check("sb_src",  32'(bus.cdb_src), 32'(e.src));
                check("sb_tag",  32'(bus.cdb_tag), 32'(e.tag));
                check("sb_data", bus.cdb_data,     e.data);
            end
        end
        prev_valid = bus.cdb_valid;
        prev_ready = bus.cdb_ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_rdy;

        rst           = 1'b1;
        flush         = 1'b0;
        bus.cdb_ready = 1'b1;
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_data  = '0;

        // Every unit offers two results; round-robin order is 0,1,2,3,0,1,2,3.
        for (int i = 0; i < N; i++) begin
            add(i, TW'(i),     32'h1000_0000 + 32'(i));
            add(i, TW'(i + 4), 32'h2000_0000 + 32'(i));
            load_unit(i);
        end
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++)
                expect_cdb(i, TW'(k * 4 + i), 32'((k + 1) << 28) + 32'(i));

        // Reset with all requests high.
        repeat (2) begin
            to_neg();
            check("ready_in_reset", 32'(bus.req_ready), 32'd0);
            edge_step();
        end
        rst = 1'b0;
        to_neg();
        check("rst_cdb_valid",   32'(bus.cdb_valid), 32'd0);
        check("rst_cdb_tag",     32'(bus.cdb_tag),   32'd0);
        check("rst_cdb_data",    bus.cdb_data,       32'd0);
        check("rst_cdb_src",     32'(bus.cdb_src),   32'd0);
        check("rst_grant_count", grant_count,        32'd0);
        check("rst_ptr",         32'(dut.ptr),       32'd0);

        // Round-robin with continuous requests.
        for (int k = 0; k < 8; k++) begin
            if (k > 0) to_neg();
            exp_rdy = N'(1 << (k % N));
            check("rr_req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            edge_step();
        end
        to_neg();
        check("rr_grant_count", grant_count,        32'd8);
        check("rr_ptr",         32'(dut.ptr),       32'd0);
        check("rr_cdb_valid",   32'(bus.cdb_valid), 32'd1);

        // Single requester: unit 2.
        edge_step();
        add(2, 4'h5, 32'hDEAD_BEEF);
        load_unit(2);
        expect_cdb(2, 4'h5, 32'hDEAD_BEEF);
        to_neg();
        check("single_req_ready", 32'(bus.req_ready), 32'b0100);
        edge_step();
        to_neg();
        check("single_cdb_valid", 32'(bus.cdb_valid), 32'd1);
        check("single_cdb_tag",   32'(bus.cdb_tag),   32'd5);
        check("single_cdb_data",  bus.cdb_data,       32'hDEAD_BEEF);
        check("single_cdb_src",   32'(bus.cdb_src),   32'd2);
        check("single_ptr",       32'(dut.ptr),       32'd3);
        check("single_count",     grant_count,        32'd9);

        // Wrap and skip: ptr=3, units 1 and 3 request.
        edge_step();
        add(1, 4'hA, 32'h1111_0001);
        add(3, 4'hB, 32'h3333_0003);
        load_unit(1);
        load_unit(3);
        expect_cdb(3, 4'hB, 32'h3333_0003);
        expect_cdb(1, 4'hA, 32'h1111_0001);
        to_neg();
        check("wrap_ready_u3", 32'(bus.req_ready), 32'b1000);
        edge_step();
        to_neg();
        check("wrap_ptr_0",    32'(dut.ptr),       32'd0);
        check("wrap_ready_u1", 32'(bus.req_ready), 32'b0010);
        edge_step();
        to_neg();
        check("wrap_ptr_2",    32'(dut.ptr),       32'd2);
        check("wrap_count",    grant_count,        32'd11);

        // Back-pressure: slot valid, consumer stalls 3 cycles, unit 0 waiting.
        edge_step();
        add(2, 4'h2, 32'h2222_2222);
        add(0, 4'h0, 32'h0000_00F0);
        load_unit(0);
        load_unit(2);
        expect_cdb(2, 4'h2, 32'h2222_2222);
        expect_cdb(0, 4'h0, 32'h0000_00F0);
        to_neg();
        check("bp_ready_u2", 32'(bus.req_ready), 32'b0100);
        edge_step();
        bus.cdb_ready = 1'b0;
        repeat (3) begin
            to_neg();
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_cdb_valid", 32'(bus.cdb_valid), 32'd1);
            check("bp_cdb_tag",   32'(bus.cdb_tag),   32'h2);
            check("bp_cdb_data",  bus.cdb_data,       32'h2222_2222);
            check("bp_cdb_src",   32'(bus.cdb_src),   32'd2);
            edge_step();
        end
        bus.cdb_ready = 1'b1;
        to_neg();
        check("bp_release_ready", 32'(bus.req_ready), 32'b0001);
        check("bp_release_ptr",   32'(dut.ptr),       32'd3);
        edge_step();
        to_neg();
        check("bp_next_valid", 32'(bus.cdb_valid), 32'd1);
        check("bp_next_src",   32'(bus.cdb_src),   32'd0);
        check("bp_count",      grant_count,        32'd13);
        check("bp_ptr",        32'(dut.ptr),       32'd1);

        // Flush while the slot is valid and unit 0 requests.
        edge_step();
        add(1, 4'h7, 32'h7777_0001);
        load_unit(1);
        expect_cdb(1, 4'h7, 32'h7777_0001);
        to_neg();
        check("fl_pre_ready", 32'(bus.req_ready), 32'b0010);
        edge_step();
        bus.cdb_ready = 1'b0;
        flush         = 1'b1;
        add(0, 4'hC, 32'hF1F1_0000);
        load_unit(0);
        expect_cdb(0, 4'hC, 32'hF1F1_0000);
        to_neg();
        check("fl_req_ready",   32'(bus.req_ready), 32'd0);
        check("fl_slot_before", 32'(bus.cdb_valid), 32'd1);
        edge_step();
        flush         = 1'b0;
        bus.cdb_ready = 1'b1;
        to_neg();
        check("fl_cdb_valid",  32'(bus.cdb_valid), 32'd0);
        check("fl_ptr",        32'(dut.ptr),       32'd2);
        check("fl_count",      grant_count,        32'd14);
        check("fl_after_rdy",  32'(bus.req_ready), 32'b0001);
        edge_step();
        to_neg();
        check("fl_u0_valid",   32'(bus.cdb_valid), 32'd1);
        check("fl_u0_src",     32'(bus.cdb_src),   32'd0);
        check("fl_u0_tag",     32'(bus.cdb_tag),   32'hC);
        check("fl_u0_count",   grant_count,        32'd15);
        check("fl_u0_ptr",     32'(dut.ptr),       32'd1);

        edge_step();
        to_neg();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter for the common data bus (CDB) between the functional units and the reorder buffer / reservation stations. Each cycle it selects at most one requesting unit, captures its result into a single registered CDB slot, and broadcasts that slot until the consumer accepts it. It is the only writer of the CDB, so functional units never drive the ROB or reservation stations directly.

## Interface
- `num_req`, default 4: number of functional-unit requesters, minimum 2.
- `req_index_bits`, default 2: width of the source index, equal to clog2(`num_req`).
- `tag_bits`, default 4: width of the ROB tag; matches the ROB index width.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `flush`  in  1  synchronous pipeline flush; drops the CDB slot and all requests in that cycle.
- `req_valid`  in  [num_req]  requester i holds a result.
- `req_tag`  in  [num_req][tag_bits]  destination ROB tag per requester.
- `req_data`  in  [num_req][32]  result value per requester.
- `req_ready`  out  [num_req]  one-hot or zero; requester i's result is accepted this cycle.
- `cdb_valid`  out  1  the CDB slot holds a result.
- `cdb_tag`  out  tag_bits  tag of the slot.
- `cdb_data`  out  32  data of the slot.
- `cdb_src`  out  req_index_bits  index of the unit that won the slot.
- `cdb_ready`  in  1  the consumer accepts the slot this cycle.
- `grant_count`  out  32  number of accepted requests since reset (performance counter).

## Operation
- State:
  - round-robin pointer `ptr` (req_index_bits);
  - CDB slot: valid, tag, data, src;
  - `grant_count`.
- `can_load = ~cdb_valid | cdb_ready`, gated by `~flush`.
- Selection: the winner is the first i with `req_valid[i]` set, scanning `ptr`, `ptr+1`, … and wrapping modulo `num_req`.
- Handshake:
  - `req_ready[winner] = can_load`; all other `req_ready` bits are 0.
  - A transfer occurs when `req_valid[i] & req_ready[i]`.
  - A requester keeps valid, tag and data stable until it sees ready.
  - A requester may not withdraw valid without a transfer, except on flush.
- On a transfer:
  - the slot loads {1, tag, data, winner};
  - `ptr` <= winner+1, or 0 if winner == `num_req`-1, so `num_req` does not need to be a power of two;
  - `grant_count` += 1, wrapping at 2^32.
- With no transfer and `cdb_ready` high, the slot clears valid; tag, data and src hold their values.
- With no transfer and `cdb_ready` low, the slot holds all of its contents.
- `ptr` is unchanged whenever no transfer occurs.
- Flush:
  - slot valid <= 0;
  - no `req_ready` bit is asserted;
  - `ptr` and `grant_count` unchanged.
- Priority: `rst` > `flush` > normal operation.

## Timing
- Reset values: `cdb_valid`=0, `cdb_tag`=0, `cdb_data`=0, `cdb_src`=0, `ptr`=0, `grant_count`=0.
  - `req_ready` is combinational and is 0 during reset.
- Latency: a request accepted on the cycle-N edge appears on the CDB outputs in cycle N+1.
- Throughput: one result per cycle while `cdb_ready` stays high. A drain and a refill of the slot occur on the same edge, with no bubble.
- Back-pressure:
  - When `cdb_valid` & ~`cdb_ready`, all `req_ready` bits are 0 and the slot is stable.
  - The CDB outputs are registered; there is no combinational path from `req_*` to `cdb_*`.
- Fairness: a continuously valid requester is granted within `num_req` transfers.
- `req_ready` depends combinationally on `req_valid`, `cdb_ready`, `flush` and the registered state only.

## Structure
- The shared CPU package holds:
  - `cdb_t` packed struct {tag, data};
  - the constants `NUM_FU` and `ROB_INDEX_BITS`.
  - The ROB and reservation stations consume the same type.
- Sub-module `rr_picker` is purely combinational:
  - inputs: `req_valid` and `ptr`;
  - outputs: a one-hot grant, `any`, and the encoded winner index.
- `cdb_arbiter` holds all sequential state and the handshake logic.

## Test plan
- **Reset:** assert `rst` for 2 cycles with all `req_valid` high. Required: `req_ready`=0; all outputs are 0.
- **Single requester:** unit 2 requests {tag 5, data 0xDEADBEEF} with `cdb_ready`=1. Required: `req_ready[2]` is high in cycle N; in N+1, `cdb_valid`=1, `cdb_tag`=5, `cdb_data`=0xDEADBEEF, `cdb_src`=2; `ptr`=3.
- **Round-robin:** all 4 units request continuously with `cdb_ready`=1 from reset. Required: `cdb_src` sequence 0,1,2,3,0,…; `grant_count`=8 after 8 cycles.
- **Back-pressure:** `cdb_ready`=0 for 3 cycles while the slot is valid. Required: the slot is unchanged and `req_ready`=0. On the cycle `cdb_ready` rises, the next winner is accepted and the new result appears the following cycle with no gap.
- **Wrap and skip:** `ptr`=3, only units 1 and 3 request. Required: grant unit 3, then unit 1; `ptr` goes 3→0→2.
- **Flush:** assert `flush` while the slot is valid and unit 0 is requesting. Required: `req_ready`=0 and `cdb_valid`=0 next cycle; `ptr` and `grant_count` are unchanged. Unit 0 is accepted on the first cycle after flush deasserts.
